// File: rtl/fetch_issue_queue.sv
// Backend fetch queue: takes dual-issue fetch pairs from the front end, compacts
// them into a circular buffer and presents the two oldest entries to decode.
module fetch_issue_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             flush,
    output logic             get_data_req,
    input  logic [1:0]       fb_valid,
    input  logic [31:0]      fb_pc1,
    input  logic [31:0]      fb_pc2,
    input  logic [31:0]      fb_inst1,
    input  logic [31:0]      fb_inst2,
    input  logic             fb_pred_taken1,
    input  logic             fb_pred_taken2,
    input  logic [31:0]      fb_pre_branch_addr1,
    input  logic [31:0]      fb_pre_branch_addr2,
    input  logic [1:0]       fb_is_exception1,
    input  logic [1:0]       fb_is_exception2,
    input  logic [6:0]       fb_pc_exception_cause1,
    input  logic [6:0]       fb_pc_exception_cause2,
    output logic [1:0]       dec_valid,
    output logic [31:0]      dec_pc1,
    output logic [31:0]      dec_pc2,
    output logic [31:0]      dec_inst1,
    output logic [31:0]      dec_inst2,
    output logic             dec_pred_taken1,
    output logic             dec_pred_taken2,
    output logic [31:0]      dec_pred_addr1,
    output logic [31:0]      dec_pred_addr2,
    output logic             dec_exc1,
    output logic             dec_exc2,
    output logic [6:0]       dec_exc_cause1,
    output logic [6:0]       dec_exc_cause2,
    input  logic [1:0]       dec_consume,
    output logic [PTR_W:0]   count,
    output logic             overflow_err
);

    localparam int ENT_W = 105;
    localparam logic [PTR_W:0]   REQ_MAX = (PTR_W+1)'(DEPTH - 4);
    localparam logic [PTR_W+1:0] DEPTH_W = (PTR_W+2)'(DEPTH);

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_inc, rd_ptr_inc;
    logic [PTR_W:0]   count_q, count_d;
    logic             flush_q;
    logic             overflow_q, overflow_d;

    logic [ENT_W-1:0] ent1, ent2, wdata0, head1, head2;
    logic             in1, in2, we0, we1;
    logic [1:0]       req_n, push_n, pop_n;
    logic [PTR_W+1:0] space;
    logic             unused_exc_lsb;

    assign unused_exc_lsb = ^{fb_is_exception1[0], fb_is_exception2[0]};

    assign ent1 = {fb_pc1, fb_inst1, fb_pred_taken1, fb_pre_branch_addr1,
                   fb_is_exception1[1], fb_pc_exception_cause1};
    assign ent2 = {fb_pc2, fb_inst2, fb_pred_taken2, fb_pre_branch_addr2,
                   fb_is_exception2[1], fb_pc_exception_cause2};

    assign wr_ptr_inc = wr_ptr_q + PTR_W'(1);
    assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);

    always_comb begin
        // A response to a request issued before a flush is dropped via flush_q.
        in1   = fb_valid[0] & ~flush & ~flush_q;
        in2   = fb_valid[1] & ~flush & ~flush_q;
        req_n = {1'b0, in1} + {1'b0, in2};

        pop_n = 2'd0;
        if (!flush) begin
            if (dec_consume == 2'b11)
                pop_n = (count_q >= 2) ? 2'd2 : count_q[1:0];
            else if (dec_consume[0])
                pop_n = (count_q != 0) ? 2'd1 : 2'd0;
        end

        space  = DEPTH_W - {1'b0, count_q} + {{PTR_W{1'b0}}, pop_n};
        push_n = req_n;
        overflow_d = overflow_q;
        if ({{PTR_W{1'b0}}, req_n} > space) begin
            push_n     = space[1:0];
            overflow_d = 1'b1;
        end

        // Slot2 moves into the first free position when slot1 is empty.
        wdata0 = in1 ? ent1 : ent2;
        we0    = (push_n != 2'd0);
        we1    = (push_n == 2'd2);

        wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
        count_d  = count_q + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            flush_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            flush_q    <= flush;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (we0) mem_q[wr_ptr_q]   <= wdata0;
        if (we1) mem_q[wr_ptr_inc] <= ent2;
    end

    assign head1 = mem_q[rd_ptr_q];
    assign head2 = mem_q[rd_ptr_inc];

    assign {dec_pc1, dec_inst1, dec_pred_taken1, dec_pred_addr1, dec_exc1, dec_exc_cause1} = head1;
    assign {dec_pc2, dec_inst2, dec_pred_taken2, dec_pred_addr2, dec_exc2, dec_exc_cause2} = head2;

    // Headroom of four covers two entries in flight plus two arriving now.
    assign get_data_req = ~cpu_rst & ~flush & ~flush_q & (count_q <= REQ_MAX);
    assign dec_valid    = {count_q >= 2, count_q != 0};
    assign count        = count_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_fetch_issue_queue.sv
// Scoreboard bench for fetch_issue_queue: a queue model of the expected entries
// is updated on every clock edge and compared against the decode-side outputs.
module tb_fetch_issue_queue;

    localparam int DEPTH = 8;

    logic        cpu_clk, cpu_rst, flush, get_data_req;
    logic [1:0]  fb_valid;
    logic [31:0] fb_pc1, fb_pc2, fb_inst1, fb_inst2;
    logic        fb_pred_taken1, fb_pred_taken2;
    logic [31:0] fb_pre_branch_addr1, fb_pre_branch_addr2;
    logic [1:0]  fb_is_exception1, fb_is_exception2;
    logic [6:0]  fb_pc_exception_cause1, fb_pc_exception_cause2;
    logic [1:0]  dec_valid, dec_consume;
    logic [31:0] dec_pc1, dec_pc2, dec_inst1, dec_inst2;
    logic        dec_pred_taken1, dec_pred_taken2;
    logic [31:0] dec_pred_addr1, dec_pred_addr2;
    logic        dec_exc1, dec_exc2;
    logic [6:0]  dec_exc_cause1, dec_exc_cause2;
    logic [3:0]  count;
    logic        overflow_err;

    fetch_issue_queue #(.DEPTH(DEPTH)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .flush(flush), .get_data_req(get_data_req),
        .fb_valid(fb_valid), .fb_pc1(fb_pc1), .fb_pc2(fb_pc2),
        .fb_inst1(fb_inst1), .fb_inst2(fb_inst2),
        .fb_pred_taken1(fb_pred_taken1), .fb_pred_taken2(fb_pred_taken2),
        .fb_pre_branch_addr1(fb_pre_branch_addr1), .fb_pre_branch_addr2(fb_pre_branch_addr2),
        .fb_is_exception1(fb_is_exception1), .fb_is_exception2(fb_is_exception2),
        .fb_pc_exception_cause1(fb_pc_exception_cause1), .fb_pc_exception_cause2(fb_pc_exception_cause2),
        .dec_valid(dec_valid), .dec_pc1(dec_pc1), .dec_pc2(dec_pc2),
        .dec_inst1(dec_inst1), .dec_inst2(dec_inst2),
        .dec_pred_taken1(dec_pred_taken1), .dec_pred_taken2(dec_pred_taken2),
        .dec_pred_addr1(dec_pred_addr1), .dec_pred_addr2(dec_pred_addr2),
        .dec_exc1(dec_exc1), .dec_exc2(dec_exc2),
        .dec_exc_cause1(dec_exc_cause1), .dec_exc_cause2(dec_exc_cause2),
        .dec_consume(dec_consume), .count(count), .overflow_err(overflow_err)
    );

    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    logic [31:0] sb[$];
    bit          m_fd;
    bit          m_ovf;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] seq_pc = 32'h1c000100;

    wire [104:0] act1 = {dec_pc1, dec_inst1, dec_pred_taken1, dec_pred_addr1, dec_exc1, dec_exc_cause1};
    wire [104:0] act2 = {dec_pc2, dec_inst2, dec_pred_taken2, dec_pred_addr2, dec_exc2, dec_exc_cause2};

    // Every metadata field is derived from the PC so one stored PC predicts a whole entry.
    function automatic logic [104:0] exp_ent(input logic [31:0] pc);
        return {pc, pc ^ 32'hA5A5A5A5, pc[2], pc + 32'h100, pc[3], pc[8:2]};
    endfunction

    task automatic set_fb(input logic [1:0] v, input logic [31:0] p1, input logic [31:0] p2);
        fb_valid = v;
        fb_pc1 = p1; fb_inst1 = p1 ^ 32'hA5A5A5A5; fb_pred_taken1 = p1[2];
        fb_pre_branch_addr1 = p1 + 32'h100; fb_is_exception1 = {p1[3], ~p1[3]};
        fb_pc_exception_cause1 = p1[8:2];
        fb_pc2 = p2; fb_inst2 = p2 ^ 32'hA5A5A5A5; fb_pred_taken2 = p2[2];
        fb_pre_branch_addr2 = p2 + 32'h100; fb_is_exception2 = {p2[3], ~p2[3]};
        fb_pc_exception_cause2 = p2[8:2];
    endtask

    task automatic push_seq(input logic [1:0] v);
        set_fb(v, seq_pc, seq_pc + 32'h4);
        seq_pc = seq_pc + 32'h8;
    endtask

    task automatic model_push(input logic [31:0] pc);
        if (sb.size() < DEPTH) sb.push_back(pc);
        else m_ovf = 1'b1;
    endtask

    task automatic tick();
        int n;
        @(posedge cpu_clk);
        if (cpu_rst) begin
            sb.delete(); m_fd = 1'b0; m_ovf = 1'b0;
        end else if (flush) begin
            sb.delete(); m_fd = 1'b1;
        end else begin
            n = (dec_consume == 2'b11) ? 2 : (dec_consume[0] ? 1 : 0);
            if (n > sb.size()) n = sb.size();
            repeat (n) void'(sb.pop_front());
            if (!m_fd) begin
                if (fb_valid[0]) model_push(fb_pc1);
                if (fb_valid[1]) model_push(fb_pc2);
            end
            m_fd = 1'b0;
        end
        #1;
        fb_valid = 2'b00; dec_consume = 2'b00; flush = 1'b0;
    endtask

    task automatic test_reset();
        cpu_rst = 1'b1;
        set_fb(2'b11, 32'h1c00_0f00, 32'h1c00_0f04);
        #2;
        total_cnt++; if (get_data_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", get_data_req); else pass_cnt++;
        total_cnt++; if (dec_valid !== 2'b00) $display("FAIL reset_dec_valid got=%b exp=00", dec_valid); else pass_cnt++;
        total_cnt++; if (count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", count); else pass_cnt++;
        total_cnt++; if (overflow_err !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", overflow_err); else pass_cnt++;
        tick();
        tick();
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        #1;
        total_cnt++; if (get_data_req !== 1'b1) $display("FAIL post_reset_req got=%b exp=1", get_data_req); else pass_cnt++;
    endtask

    task automatic test_fill_throttle();
        bit prev_req = 1'b0;
        for (int i = 0; i < 7; i++) begin
            total_cnt++;
            if (get_data_req !== (sb.size() <= DEPTH - 4))
                $display("FAIL fill_req cyc=%0d got=%b exp=%b", i, get_data_req, sb.size() <= DEPTH - 4);
            else pass_cnt++;
            if (prev_req) push_seq(2'b11);
            prev_req = get_data_req;
            tick();
            total_cnt++;
            if (count !== 4'(sb.size()) || overflow_err !== 1'b0)
                $display("FAIL fill_count cyc=%0d got=%0d/%b exp=%0d/0", i, count, overflow_err, sb.size());
            else pass_cnt++;
        end
        total_cnt++; if (count !== 4'd8) $display("FAIL fill_full got=%0d exp=8", count); else pass_cnt++;
        for (int i = 0; i < DEPTH && sb.size() > 0; i++) begin
            total_cnt++;
            if (dec_valid !== {sb.size() >= 2, 1'b1} || act1 !== exp_ent(sb[0]))
                $display("FAIL drain_head i=%0d got=%b/%h exp_pc=%h", i, dec_valid, dec_pc1, sb[0]);
            else pass_cnt++;
            if (sb.size() >= 2) begin
                total_cnt++;
                if (act2 !== exp_ent(sb[1])) $display("FAIL drain_slot2 i=%0d got=%h exp=%h", i, dec_pc2, sb[1]);
                else pass_cnt++;
            end
            dec_consume = 2'b11;
            tick();
        end
        total_cnt++; if (count !== 4'd0) $display("FAIL drain_empty got=%0d exp=0", count); else pass_cnt++;
    endtask

    task automatic test_pair();
        set_fb(2'b11, 32'h1c000000, 32'h1c000004);
        tick();
        total_cnt++; if (dec_valid !== 2'b11) $display("FAIL pair_valid got=%b exp=11", dec_valid); else pass_cnt++;
        total_cnt++; if (dec_pc1 !== 32'h1c000000) $display("FAIL pair_pc1 got=%h exp=1c000000", dec_pc1); else pass_cnt++;
        total_cnt++; if (dec_pc2 !== 32'h1c000004) $display("FAIL pair_pc2 got=%h exp=1c000004", dec_pc2); else pass_cnt++;
        total_cnt++; if (act1 !== exp_ent(sb[0]) || act2 !== exp_ent(sb[1]))
            $display("FAIL pair_fields got=%h/%h exp=%h/%h", act1, act2, exp_ent(sb[0]), exp_ent(sb[1])); else pass_cnt++;
        dec_consume = 2'b11;
        tick();
        total_cnt++; if (dec_valid !== 2'b00 || count !== 4'd0) $display("FAIL pair_pop got=%b/%0d exp=00/0", dec_valid, count); else pass_cnt++;
    endtask

    task automatic test_compact();
        set_fb(2'b10, 32'hdeadbee0, 32'h1c000010);
        tick();
        total_cnt++; if (dec_valid !== 2'b01) $display("FAIL compact_valid got=%b exp=01", dec_valid); else pass_cnt++;
        total_cnt++; if (dec_pc1 !== 32'h1c000010) $display("FAIL compact_pc got=%h exp=1c000010", dec_pc1); else pass_cnt++;
        total_cnt++; if (count !== 4'd1) $display("FAIL compact_count got=%0d exp=1", count); else pass_cnt++;
        dec_consume = 2'b10;
        tick();
        total_cnt++; if (count !== 4'd1 || dec_pc1 !== 32'h1c000010) $display("FAIL consume10 got=%0d/%h exp=1/1c000010", count, dec_pc1); else pass_cnt++;
        dec_consume = 2'b11;
        tick();
        total_cnt++; if (count !== 4'd0 || dec_valid !== 2'b00) $display("FAIL clip_pop got=%0d/%b exp=0/00", count, dec_valid); else pass_cnt++;
    endtask

    task automatic test_push_pop_wrap();
        push_seq(2'b11); tick();
        push_seq(2'b01); tick();
        total_cnt++; if (count !== 4'd3) $display("FAIL pp_setup got=%0d exp=3", count); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            total_cnt++;
            if (act1 !== exp_ent(sb[0]) || dec_pc2 !== sb[1])
                $display("FAIL pp_head i=%0d got=%h/%h exp=%h/%h", i, dec_pc1, dec_pc2, sb[0], sb[1]);
            else pass_cnt++;
            push_seq(2'b11);
            dec_consume = 2'b11;
            tick();
            total_cnt++; if (count !== 4'd3) $display("FAIL pp_count i=%0d got=%0d exp=3", i, count); else pass_cnt++;
        end
        total_cnt++; if (dec_pc1 !== sb[0] || dec_pc2 !== sb[1]) $display("FAIL pp_final got=%h/%h exp=%h/%h", dec_pc1, dec_pc2, sb[0], sb[1]); else pass_cnt++;
        dec_consume = 2'b11; tick();
        dec_consume = 2'b01; tick();
        total_cnt++; if (count !== 4'd0) $display("FAIL pp_drain got=%0d exp=0", count); else pass_cnt++;
    endtask

    task automatic test_flush();
        push_seq(2'b11); tick();
        push_seq(2'b11); tick();
        push_seq(2'b01); tick();
        total_cnt++; if (count !== 4'd5) $display("FAIL flush_setup got=%0d exp=5", count); else pass_cnt++;
        flush = 1'b1;
        push_seq(2'b11);
        dec_consume = 2'b11;
        #1;
        total_cnt++; if (get_data_req !== 1'b0) $display("FAIL flush_req_c0 got=%b exp=0", get_data_req); else pass_cnt++;
        tick();
        total_cnt++; if (count !== 4'd0 || dec_valid !== 2'b00) $display("FAIL flush_clear got=%0d/%b exp=0/00", count, dec_valid); else pass_cnt++;
        total_cnt++; if (get_data_req !== 1'b0) $display("FAIL flush_req_c1 got=%b exp=0", get_data_req); else pass_cnt++;
        push_seq(2'b11);
        tick();
        total_cnt++; if (count !== 4'(sb.size()) || count !== 4'd0) $display("FAIL flush_drop got=%0d exp=0", count); else pass_cnt++;
        total_cnt++; if (get_data_req !== 1'b1) $display("FAIL flush_req_c2 got=%b exp=1", get_data_req); else pass_cnt++;
    endtask

    task automatic test_overflow();
        push_seq(2'b11); tick();
        push_seq(2'b11); tick();
        push_seq(2'b11); tick();
        push_seq(2'b01); tick();
        total_cnt++; if (count !== 4'd7) $display("FAIL ovf_setup got=%0d exp=7", count); else pass_cnt++;
        push_seq(2'b11);
        tick();
        total_cnt++; if (count !== 4'd8) $display("FAIL ovf_count got=%0d exp=8", count); else pass_cnt++;
        total_cnt++; if (overflow_err !== m_ovf || m_ovf !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", overflow_err); else pass_cnt++;
        for (int i = 0; i < DEPTH && sb.size() > 0; i++) begin
            total_cnt++;
            if (act1 !== exp_ent(sb[0])) $display("FAIL ovf_drain i=%0d got=%h exp=%h", i, dec_pc1, sb[0]);
            else pass_cnt++;
            dec_consume = 2'b01;
            tick();
        end
        flush = 1'b1;
        tick();
        total_cnt++; if (overflow_err !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", overflow_err); else pass_cnt++;
        tick();
        cpu_rst = 1'b1;
        #1;
        total_cnt++; if (overflow_err !== 1'b0 || count !== 4'd0) $display("FAIL ovf_reset got=%b/%0d exp=0/0", overflow_err, count); else pass_cnt++;
        tick();
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
    endtask

    initial begin
        cpu_rst = 1'b1;
        flush = 1'b0;
        dec_consume = 2'b00;
        m_fd = 1'b0;
        m_ovf = 1'b0;
        set_fb(2'b00, 32'h0, 32'h0);
        test_reset();
        test_fill_throttle();
        test_pair();
        test_compact();
        test_push_pop_wrap();
        test_flush();
        test_overflow();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_issue_queue.md
Name: fetch_issue_queue

Overview:
- Backend-side receiver for the front end's dual-issue instruction stream (fb_* bundle). It is the consumer of that stream and the source of get_data_req.
- Holds up to DEPTH fetched instructions with their PC, prediction and exception metadata in a circular queue.
- Compacts partially valid fetch pairs and presents the oldest two entries to decode in program order.
- Throttles the front end through get_data_req and discards all in-flight state on a pipeline flush.

Parameters:
- DEPTH, 8, queue entries; power of two, minimum 4.
- PTR_W, log2(DEPTH), read/write pointer width; count width is PTR_W+1.

Ports:
- cpu_clk  in  1  clock.
- cpu_rst  in  1  reset, asynchronous, active-high.
- flush  in  1  backend flush; discards queue contents.
- get_data_req  out  1  request for one fetch pair from the front end.
- fb_valid  in  2  per-slot valid for the incoming pair; bit0 is slot1, bit1 is slot2.
- fb_pc1 / fb_pc2  in  32  slot PCs.
- fb_inst1 / fb_inst2  in  32  slot instructions.
- fb_pred_taken1 / fb_pred_taken2  in  1  BPU predicted taken.
- fb_pre_branch_addr1 / fb_pre_branch_addr2  in  32  predicted target.
- fb_is_exception1 / fb_is_exception2  in  2  exception flags; only bit1 is meaningful.
- fb_pc_exception_cause1 / fb_pc_exception_cause2  in  7  fetch exception cause.
- dec_valid  out  2  head entries valid; bit0 is the oldest entry.
- dec_pc1 / dec_pc2  out  32  PCs of the two oldest entries.
- dec_inst1 / dec_inst2  out  32  instructions of the two oldest entries.
- dec_pred_taken1 / dec_pred_taken2  out  1  predicted taken of the two oldest entries.
- dec_pred_addr1 / dec_pred_addr2  out  32  predicted targets of the two oldest entries.
- dec_exc1 / dec_exc2  out  1  exception flag (fb_is_exception bit1).
- dec_exc_cause1 / dec_exc_cause2  out  7  exception cause.
- dec_consume  in  2  decode takes entries: 01 takes one, 11 takes two, 00 takes none; 10 is treated as 00.
- count  out  PTR_W+1  current occupancy.
- overflow_err  out  1  sticky overflow flag.

Behaviour:
- Reset (asynchronous, cpu_rst high):
  - wr_ptr, rd_ptr, count and overflow_err all go to 0; flush_d goes to 0.
  - get_data_req and dec_valid are 0 while reset is high.
  - dec_* data outputs are don't-care while the matching dec_valid bit is 0.
- Request rule:
  - get_data_req = !flush && !flush_d && (count <= DEPTH-4). This is combinational from registers.
  - The front end returns data in the cycle after the request. Worst case is two entries in flight plus two arriving this cycle, so the headroom of 4 guarantees no overflow.
- Push:
  - Each cycle the valid slots of fb_valid are written at wr_ptr in order slot1 then slot2. Invalid slots are skipped.
    - 01 pushes 1 entry (slot1).
    - 10 pushes 1 entry (slot2, compacted).
    - 11 pushes 2 entries.
  - Pushes are accepted whether or not a request was pending.
  - wr_ptr advances by the number of entries pushed, modulo DEPTH.
- Pop:
  - pop_n = dec_consume==11 ? min(2,count) : dec_consume[0] ? min(1,count) : 0.
  - Consuming more than the valid entries is clipped to the valid entries.
  - rd_ptr advances by pop_n, modulo DEPTH.
- Count and simultaneous push/pop:
  - count_next = count + push_n - pop_n, evaluated on the pre-update count.
  - A full queue may push in the same cycle as it pops.
- Output:
  - dec_valid[0] = count>=1; dec_valid[1] = count>=2.
  - Slot 1 outputs show entry rd_ptr; slot 2 outputs show entry rd_ptr+1 (wrapping).
  - Push-to-visible latency is 1 cycle. There is no bypass.
- Overflow:
  - If count - pop_n + push_n > DEPTH, only the entries that fit are written (slot1 first).
  - overflow_err is set and stays set until reset.
- Flush:
  - When flush is high at a clock edge: wr_ptr, rd_ptr and count go to 0, and the same-cycle fb input and dec_consume are ignored.
  - flush_d <= flush. While flush_d is 1, fb_valid is also ignored, which drops a response to a pre-flush request.
  - get_data_req is low in the flush cycle and the following cycle.
  - dec_valid is 00 from the cycle after flush.
  - Back-to-back flushes extend the window.
- Reset mid-operation: immediately returns to the reset state described above. No stored data survives.

Test Plan:
1. Reset, then hold fb_valid=11 each cycle after a request, with dec_consume=00:
   - get_data_req drops once count reaches 6 (DEPTH=8). count never exceeds 8 and overflow_err stays 0.
2. Push pair PC 0x1c000000/0x1c000004 with fb_valid=11:
   - Next cycle dec_valid=11, dec_pc1=0x1c000000, dec_pc2=0x1c000004.
3. fb_valid=10 with fb_pc2=0x1c000010, queue empty:
   - Next cycle dec_valid=01, dec_pc1=0x1c000010, count=1.
4. Queue holds 3 entries; in one cycle push 11 and consume 11:
   - count stays 3 and head advances two entries. Repeat across the wrap: with the pointer at 7, the next entry appears at index 0 in order.
5. Queue holds 5 entries, flush=1 with fb_valid=11, then fb_valid=11 in the next cycle:
   - Both pushes are dropped and count=0.
   - get_data_req is low for 2 cycles and returns high on the 3rd.
6. Force fb_valid=11 with count=7 and dec_consume=00:
   - Only slot1 is written, count=8 and overflow_err=1.
   - overflow_err stays 1 through a flush and clears only on cpu_rst.
